// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver and the transmitter:
//   - CLKS_PER_BIT_DEF : clk100 cycles per bit (100 MHz / 115200 baud)
//   - DATA_BITS        : data bits per frame (8N1)
//   - STOP_BITS        : stop bits per frame
//   - uart_state_t     : FSM state encoding shared by RX/TX
//   - majority3()      : 2-of-3 vote used for noise-tolerant bit sampling
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input. Both flops reset to 1
// so an idle-high serial line does not produce a false edge on reset release.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous reset, active-low
//   i_d     : asynchronous input
//   o_q     : synchronized output
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver, LSB first, with a valid/ready byte output.
// Ports:
//   clk100       : system clock (100 MHz)
//   rst_n        : asynchronous reset, active-low
//   UartRx       : asynchronous serial line, idle high
//   rx_data      : received byte, stable while rx_valid=1
//   rx_valid     : a byte is available
//   rx_ready     : consumer accepts the byte
//   rx_frame_err : one-cycle pulse, stop bit sampled as 0
//   rx_overrun   : one-cycle pulse, byte completed while output still full
//   rx_busy      : FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk100,
    input  logic       rst_n,
    input  logic       UartRx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LAST_IDX    = 3'(DATA_BITS - 1);

    logic              w_rx;
    logic              r_rx_d;
    logic              r_fall;
    uart_state_t       r_state;
    uart_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_s2;
    logic              r_s1;
    logic              w_vote;
    logic              w_expired;
    logic              w_deliver;
    logic              w_ferr;

    sync_2ff u_sync (
        .i_clk   (clk100),
        .i_rst_n (rst_n),
        .i_d     (UartRx),
        .o_q     (w_rx)
    );

    // Start-edge detector; registered so IDLE reacts to a clean one-cycle pulse.
    // Samples at counter values 2 and 1 are held for the 2-of-3 vote taken at 0.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_d <= 1'b1;
            r_fall <= 1'b0;
            r_s2   <= 1'b1;
            r_s1   <= 1'b1;
        end else begin
            r_rx_d <= w_rx;
            r_fall <= r_rx_d & ~w_rx;
            if (r_cnt == CNT_W'(2)) r_s2 <= w_rx;
            if (r_cnt == CNT_W'(1)) r_s1 <= w_rx;
        end
    end

    assign w_vote    = majority3(r_s2, r_s1, w_rx);
    assign w_expired = (r_cnt == '0);

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_fall) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (!w_expired) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_rx) begin
                    // Line back high at start-bit centre: glitch, not a frame.
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = BIT_RELOAD;
                    w_idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (!w_expired) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_shift_nxt[r_idx] = w_vote;
                    w_cnt_nxt          = BIT_RELOAD;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == LAST_IDX) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!w_expired) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    // Leave at stop-bit centre so the next start edge is not missed.
                    w_state_nxt = ST_IDLE;
                    w_deliver   = w_vote;
                    w_ferr      = ~w_vote;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= w_ferr;
            rx_overrun   <= 1'b0;
            if (w_deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (w_deliver) begin
                // Output still held by the consumer: drop the new byte.
                rx_overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
// Self-checking bench for uart_rx_byte with a reduced bit period
// (32 clocks per bit) so full frames stay short. Expected bytes are queued
// when a frame is driven and compared when the DUT hands a byte over.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int CLKS  = 32;
    localparam int HALF  = CLKS / 2;
    localparam int CLK_T = 10;
    localparam int BIT_T = CLKS * CLK_T;

    logic       clk100   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       UartRx   = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int         n_checks    = 0;
    int         n_fail      = 0;
    logic [7:0] sb_q[$];
    int         valid_rises = 0;
    int         ferr_cnt    = 0;
    int         ovr_cnt     = 0;
    int         busy_cnt    = 0;
    logic       valid_d     = 1'b0;
    longint     t_fall      = 0;
    longint     t_rise      = 0;
    longint     t_rise_prev = 0;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS),
        .HALF_BIT     (HALF)
    ) dut (
        .clk100       (clk100),
        .rst_n        (rst_n),
        .UartRx       (UartRx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #(CLK_T / 2) clk100 = ~clk100;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: counts pulses and scores every accepted byte.
    always @(negedge clk100) begin
        if (rx_busy) busy_cnt++;
        if (rx_frame_err) ferr_cnt++;
        if (rx_overrun) ovr_cnt++;
        if (rx_valid && !valid_d) begin
            valid_rises++;
            t_rise_prev = t_rise;
            t_rise      = longint'($time) - CLK_T / 2;
        end
        valid_d = rx_valid;
        if (rx_valid && rx_ready) begin
            check_eq("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) check_eq("rx_data", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit expect_rx);
        if (expect_rx) sb_q.push_back(b);
        t_fall = longint'($time);
        UartRx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            UartRx = b[i];
            #(BIT_T);
        end
        UartRx = stop_bit;
        #(BIT_T);
        UartRx = 1'b1;
    endtask

    initial begin
        int     rises0;
        int     ferr0;
        int     ovr0;
        longint lat;
        longint gap;
        longint lat_lo;
        longint lat_hi;

        lat_lo = longint'((CLKS * 19 / 2 + 3) * CLK_T);
        lat_hi = longint'((CLKS * 19 / 2 + 4) * CLK_T);

        // Reset state
        idle(3);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data", {24'd0, rx_data}, 32'h00);
        check_eq("rst_busy", 32'(rx_busy), 32'd0);
        check_eq("rst_ferr", 32'(rx_frame_err), 32'd0);
        check_eq("rst_ovr", 32'(rx_overrun), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Single byte 0x40, latency
        rises0 = valid_rises; ferr0 = ferr_cnt; ovr0 = ovr_cnt;
        send_byte(8'h40, 1'b1, 1'b1);
        idle(10);
        check_eq("b40_rises", 32'(valid_rises - rises0), 32'd1);
        check_eq("b40_ferr", 32'(ferr_cnt - ferr0), 32'd0);
        check_eq("b40_ovr", 32'(ovr_cnt - ovr0), 32'd0);
        lat = t_rise - t_fall;
        check_eq("b40_latency_in_window", 32'(lat >= lat_lo && lat <= lat_hi), 32'd1);

        // Back-to-back 0x55, 0xAA
        rises0 = valid_rises;
        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'hAA, 1'b1, 1'b1);
        idle(10);
        check_eq("b2b_rises", 32'(valid_rises - rises0), 32'd2);
        gap = t_rise - t_rise_prev;
        check_eq("b2b_gap_one_frame", 32'(gap >= longint'(10 * BIT_T - CLK_T) && gap <= longint'(10 * BIT_T + CLK_T)), 32'd1);

        // Short low glitch
        rises0 = valid_rises; ferr0 = ferr_cnt; busy_cnt = 0;
        UartRx = 1'b0;
        #(11 * CLK_T);
        UartRx = 1'b1;
        idle(40);
        check_eq("glitch_busy_cycles", 32'(busy_cnt), 32'(HALF));
        check_eq("glitch_idle", 32'(rx_busy), 32'd0);
        check_eq("glitch_rises", 32'(valid_rises - rises0), 32'd0);
        check_eq("glitch_ferr", 32'(ferr_cnt - ferr0), 32'd0);

        // Framing error, then a good frame
        rises0 = valid_rises; ferr0 = ferr_cnt;
        send_byte(8'h05, 1'b0, 1'b0);
        idle(10);
        check_eq("ferr_pulses", 32'(ferr_cnt - ferr0), 32'd1);
        check_eq("ferr_no_rise", 32'(valid_rises - rises0), 32'd0);
        check_eq("ferr_valid_low", 32'(rx_valid), 32'd0);
        send_byte(8'h05, 1'b1, 1'b1);
        idle(10);
        check_eq("ferr_recover_rises", 32'(valid_rises - rises0), 32'd1);
        check_eq("ferr_recover_no_err", 32'(ferr_cnt - ferr0), 32'd1);

        // Overrun with consumer stalled
        @(posedge clk100); #1 rx_ready = 1'b0;
        idle(2);
        ovr0 = ovr_cnt;
        send_byte(8'h11, 1'b1, 1'b1);
        send_byte(8'h22, 1'b1, 1'b0);
        idle(10);
        check_eq("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        check_eq("ovr_valid_held", 32'(rx_valid), 32'd1);
        check_eq("ovr_data_held", {24'd0, rx_data}, 32'h11);
        @(posedge clk100); #1 rx_ready = 1'b1;
        @(posedge clk100); #1;
        check_eq("ovr_valid_cleared", 32'(rx_valid), 32'd0);
        idle(2);

        // Reset during bit 4 of 0x5A, then 0x3C
        rises0 = valid_rises;
        fork
            send_byte(8'h5A, 1'b1, 1'b0);
            begin
                #(BIT_T * 5 + BIT_T / 2 + 2);
                rst_n = 1'b0;
                #1;
                check_eq("midrst_busy", 32'(rx_busy), 32'd0);
                check_eq("midrst_valid", 32'(rx_valid), 32'd0);
                check_eq("midrst_data", {24'd0, rx_data}, 32'h00);
            end
        join
        idle(3);
        rst_n = 1'b1;
        idle(5);
        send_byte(8'h3C, 1'b1, 1'b1);
        idle(10);
        check_eq("midrst_rises", 32'(valid_rises - rises0), 32'd1);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk100 cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter HALF_BIT, default CLKS_PER_BIT/2, meaning the cycle count from the start-bit falling edge to the start-bit centre.
REQ-003 SHALL have port clk100, input, 1 bit: the single system clock, 100 MHz.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have port UartRx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data, output, 8 bits: received byte, held stable while rx_valid=1.
REQ-007 SHALL have port rx_valid, output, 1 bit: a byte is available.
REQ-008 SHALL have port rx_ready, input, 1 bit: the consumer accepts the byte.
REQ-009 SHALL have port rx_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.
REQ-010 SHALL have port rx_overrun, output, 1 bit: one-cycle pulse when a new byte completes while rx_valid=1 and rx_ready=0.
REQ-011 SHALL have port rx_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass UartRx through a 2-flop synchronizer; all downstream logic SHALL use only the synchronized signal.
REQ-013 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-014 IDLE -> START on a synchronized 1->0 transition, and SHALL load the bit counter with HALF_BIT-1.
REQ-015 START: at counter expiry, if the sampled line is 1 (false start/glitch) -> IDLE with no output; otherwise -> DATA, loading CLKS_PER_BIT-1 and setting bit index = 0.
REQ-016 DATA: at each counter expiry, SHALL shift the sample into bit[index] (LSB first) and reload the counter; after index 7 -> STOP.
REQ-017 Each data/stop sample SHALL be a majority vote of the synchronized line at counter values 1, 0 and the cycle before 1 (3 samples around bit centre).
REQ-018 STOP: at counter expiry, if the sample is 1 -> deliver the byte (REQ-019) and go to IDLE; if 0 -> pulse rx_frame_err, discard the byte, go to IDLE.
REQ-019 Delivery, with rx_valid=0 or (rx_valid=1 and rx_ready=1) in the same cycle: SHALL load rx_data and set rx_valid=1 on the next edge.
REQ-020 Delivery with rx_valid=1 and rx_ready=0: SHALL keep the old rx_data/rx_valid, discard the new byte, and pulse rx_overrun.
REQ-021 rx_valid SHALL clear on the edge after a cycle with rx_valid=1 and rx_ready=1, unless a delivery occurs in that same cycle (REQ-019).
REQ-022 Return to IDLE at the stop-bit centre SHALL allow the next start edge to be detected without waiting for the stop-bit end.
REQ-023 Latency: rx_valid SHALL rise 9.5 bit times + 3 to 4 cycles after the UartRx falling edge.
REQ-024 The counter SHALL be wide enough for CLKS_PER_BIT-1 (10 bits at default); the bit index SHALL be 3 bits.

Reset
REQ-025 rst_n=0 SHALL asynchronously force FSM=IDLE, both synchronizer flops=1, rx_data=8'h00, and rx_valid, rx_frame_err, rx_overrun and rx_busy all 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a new falling edge and produce no partial byte.

Structure
REQ-027 CLKS_PER_BIT default, the FSM state encodings and the frame constants (8 data bits, 1 stop bit) SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-028 The synchronizer SHALL be the sub-module sync_2ff, reset value 1; all other logic SHALL be in uart_rx_byte.

Verification (bit time 8680.555 ns; bench uses the existing sendByte-style task)
REQ-029 SHALL cover: send 8'b01000000 with rx_ready=1 -> exactly one rx_valid pulse, rx_data=8'h40, no error pulses.
REQ-030 SHALL cover: send 0x55 then 0xAA back-to-back with rx_ready=1 -> two deliveries, 0x55 then 0xAA, about 86.8 us apart.
REQ-031 SHALL cover: a 3 us low glitch on UartRx -> rx_busy high for 434 cycles, then back to IDLE with no rx_valid and no rx_frame_err.
REQ-032 SHALL cover: send 0x05 with stop bit driven 0 -> one rx_frame_err pulse, rx_valid stays 0, then a correct 0x05 frame is received normally.
REQ-033 SHALL cover: rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one rx_overrun pulse; raise rx_ready -> rx_valid clears after one cycle.
REQ-034 SHALL cover: assert rst_n=0 during bit 4 of 0x5A, release, send 0x3C -> only 0x3C is delivered.
